// File: rtl/axis_bulk_packetizer_pkg.sv
// Shared USB bulk-endpoint constants used by the AXI-Stream packetizer.
package axis_bulk_packetizer_pkg;

  localparam int unsigned MAX_PACKET_HS   = 512;
  localparam int unsigned MAX_PACKET_FS   = 64;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  // Reason the held byte is being closed out as the last byte of a packet.
  typedef enum logic [1:0] {
    CLOSE_NONE,
    CLOSE_DATA,
    CLOSE_TIMER
  } close_cause_e;

endpackage

// File: rtl/axis_bulk_packetizer.sv
// Splits an 8-bit AXI-Stream into USB bulk IN packets of at most MAX_PACKET
// bytes, closing short packets on upstream tlast, flush, or an idle timeout.
module axis_bulk_packetizer
  import axis_bulk_packetizer_pkg::*;
#(
  parameter int unsigned MAX_PACKET = MAX_PACKET_HS,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic [7:0] s_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic [7:0] m_axis_tdata,
  input  logic       flush,
  output logic       timeout_o
);

  localparam int unsigned CW = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic          ready_en;
  logic          hold_valid;
  logic          hold_last;
  logic [7:0]    hold_data;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;

  logic          out_space;
  logic          data_close;
  logic          timer_hit;
  logic          promote;
  logic          accept;
  close_cause_e  cause;

  // The held byte can only be finalised once its successor arrives or an
  // explicit close condition exists; the timer close loses to a new byte.
  always_comb begin
    out_space     = !m_axis_tvalid || m_axis_tready;
    data_close    = hold_valid && (hold_last || (count == CW'(MAX_PACKET - 1)) || flush);
    timer_hit     = (TIMEOUT != 0) && (timer == TW'(TIMEOUT));
    promote       = hold_valid && out_space && (data_close || timer_hit || s_axis_tvalid);
    s_axis_tready = ready_en && (!hold_valid || promote);
    accept        = s_axis_tvalid && s_axis_tready;
    cause         = CLOSE_NONE;
    if (data_close)
      cause = CLOSE_DATA;
    else if (timer_hit && !accept)
      cause = CLOSE_TIMER;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en      <= 1'b0;
      hold_valid    <= 1'b0;
      hold_last     <= 1'b0;
      hold_data     <= '0;
      count         <= '0;
      timer         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      timeout_o     <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      timeout_o <= promote && (cause == CLOSE_TIMER);

      if (accept) begin
        hold_valid <= 1'b1;
        hold_last  <= s_axis_tlast;
        hold_data  <= s_axis_tdata;
      end else if (promote) begin
        hold_valid <= 1'b0;
      end

      if (promote) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= hold_data;
        m_axis_tlast  <= (cause != CLOSE_NONE);
        count         <= (cause != CLOSE_NONE) ? '0 : count + CW'(1);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (accept || promote)
        timer <= '0;
      else if (hold_valid && !data_close && !timer_hit && (TIMEOUT != 0))
        timer <= timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_axis_bulk_packetizer.sv
// Directed-vector bench for axis_bulk_packetizer (MAX_PACKET=512, TIMEOUT=1024).
module tb_axis_bulk_packetizer;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b1;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic [7:0] s_axis_tdata = '0;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       flush = 1'b0;
  logic       timeout_o;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] beats[$];
  int tmo_pulses = 0;

  always #5 aclk = ~aclk;

  axis_bulk_packetizer #(.MAX_PACKET(512), .TIMEOUT(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .flush(flush), .timeout_o(timeout_o)
  );

  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
    if (timeout_o) tmo_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send(input int n, input int first, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit ok;
      guard = 0;
      ok = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(first + i);
      s_axis_tlast  = last_at_end && (i == n - 1);
      do begin
        @(negedge aclk);
        ok = s_axis_tready;
        @(posedge aclk); #1;
        guard++;
      end while (!ok && guard < 500);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL send_accept: byte %0d s_axis_tready=0 for %0d cycles, required 1", i, guard);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    #2 aresetn = 1'b0;
    #3;
    vectors++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, timeout_o} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 000",
               {m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, timeout_o});
    end
    idle(3);
    aresetn = 1'b1;
    #1;
    vectors++;
    if (s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_before_edge: got %b, required 0", s_axis_tready);
    end
    @(posedge aclk); #1;
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_after_edge: got %b, required 1", s_axis_tready);
    end
  endtask

  task automatic test_tlast_message();
    beats.delete(); tmo_pulses = 0;
    send(10, 8'hA0, 1'b1);
    vectors++;
    if (m_axis_tlast !== 1'b0 || m_axis_tdata !== 8'hA8) begin
      miscompares++;
      $display("FAIL msg_prev_beat: got last=%b data=%h, required last=0 data=a8", m_axis_tlast, m_axis_tdata);
    end
    @(posedge aclk); #1;
    vectors++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b11, 8'hA9}) begin
      miscompares++;
      $display("FAIL msg_latency: got v=%b l=%b d=%h, required v=1 l=1 d=a9", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    idle(4);
    vectors++;
    if (beats.size() !== 10) begin
      miscompares++;
      $display("FAIL msg_len: got %0d beats, required 10", beats.size());
    end
    for (int i = 0; i < 10 && i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== {(i == 9), 8'(8'hA0 + i)}) begin
        miscompares++;
        $display("FAIL msg_beat %0d: got %h, required %h", i, beats[i], {(i == 9), 8'(8'hA0 + i)});
        break;
      end
    end
    vectors++;
    if (tmo_pulses !== 0) begin
      miscompares++;
      $display("FAIL msg_timeout: got %0d pulses, required 0", tmo_pulses);
    end
  endtask

  task automatic test_flush();
    beats.delete(); tmo_pulses = 0;
    send(3, 8'h30, 1'b0);
    idle(4);
    flush = 1'b1;
    @(posedge aclk); #1;
    flush = 1'b0;
    idle(3);
    vectors++;
    if (beats.size() !== 3) begin
      miscompares++;
      $display("FAIL flush_len: got %0d beats, required 3", beats.size());
    end
    for (int i = 0; i < 3 && i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== {(i == 2), 8'(8'h30 + i)}) begin
        miscompares++;
        $display("FAIL flush_beat %0d: got %h, required %h", i, beats[i], {(i == 2), 8'(8'h30 + i)});
      end
    end
    vectors++;
    if (tmo_pulses !== 0) begin
      miscompares++;
      $display("FAIL flush_timeout: got %0d pulses, required 0", tmo_pulses);
    end
    flush = 1'b1;
    @(posedge aclk); #1;
    flush = 1'b0;
    idle(3);
    vectors++;
    if (beats.size() !== 3 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: got %0d beats tvalid=%b, required 3 beats tvalid=0", beats.size(), m_axis_tvalid);
    end
  endtask

  task automatic test_timeout_stream();
    beats.delete(); tmo_pulses = 0;
    send(1200, 0, 1'b0);
    idle(1024);
    vectors++;
    if (beats.size() !== 1199 || tmo_pulses !== 0) begin
      miscompares++;
      $display("FAIL stream_pre_timeout: got %0d beats %0d pulses, required 1199 beats 0 pulses", beats.size(), tmo_pulses);
    end
    idle(2);
    vectors++;
    if (beats.size() !== 1200) begin
      miscompares++;
      $display("FAIL stream_len: got %0d beats, required 1200", beats.size());
    end
    for (int i = 0; i < 1200 && i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== {(i == 511 || i == 1023 || i == 1199), 8'(i)}) begin
        miscompares++;
        $display("FAIL stream_beat %0d: got %h, required %h", i, beats[i], {(i == 511 || i == 1023 || i == 1199), 8'(i)});
        break;
      end
    end
    idle(3);
    vectors++;
    if (tmo_pulses !== 1) begin
      miscompares++;
      $display("FAIL stream_timeout_pulse: got %0d pulses, required 1", tmo_pulses);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] snap;
    bit unstable;
    beats.delete(); tmo_pulses = 0;
    unstable = 1'b0;
    fork
      send(40, 8'h40, 1'b1);
      begin
        idle(5);
        m_axis_tready = 1'b0;
        @(negedge aclk);
        snap = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
        repeat (100) begin
          @(negedge aclk);
          if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== snap) unstable = 1'b1;
        end
        vectors++;
        if (unstable || snap[9] !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_stable: got unstable=%b snap=%h, required stable valid output", unstable, snap);
        end
        vectors++;
        if (s_axis_tready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_upstream_ready: got %b, required 0", s_axis_tready);
        end
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
      end
    join
    idle(5);
    vectors++;
    if (beats.size() !== 40) begin
      miscompares++;
      $display("FAIL bp_len: got %0d beats, required 40", beats.size());
    end
    for (int i = 0; i < 40 && i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== {(i == 39), 8'(8'h40 + i)}) begin
        miscompares++;
        $display("FAIL bp_beat %0d: got %h, required %h", i, beats[i], {(i == 39), 8'(8'h40 + i)});
        break;
      end
    end
  endtask

  task automatic test_new_byte_wins();
    beats.delete(); tmo_pulses = 0;
    send(1, 8'h77, 1'b0);
    idle(1024);
    send(1, 8'h78, 1'b1);
    idle(4);
    vectors++;
    if (beats.size() !== 2) begin
      miscompares++;
      $display("FAIL race_len: got %0d beats, required 2", beats.size());
    end else begin
      vectors++;
      if (beats[0] !== 9'h077 || beats[1] !== 9'h178) begin
        miscompares++;
        $display("FAIL race_beats: got %h %h, required 077 178", beats[0], beats[1]);
      end
    end
    vectors++;
    if (tmo_pulses !== 0) begin
      miscompares++;
      $display("FAIL race_timeout: got %0d pulses, required 0", tmo_pulses);
    end
  endtask

  task automatic test_reset_mid_packet();
    send(300, 8'h11, 1'b0);
    #2 aresetn = 1'b0;
    #1;
    vectors++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, timeout_o} !== 12'h000) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h, required 000",
               {m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, timeout_o});
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    beats.delete();
    idle(1);
    send(600, 0, 1'b0);
    idle(3);
    vectors++;
    if (beats.size() < 512) begin
      miscompares++;
      $display("FAIL midreset_len: got %0d beats, required at least 512", beats.size());
    end
    for (int i = 0; i < 512 && i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== {(i == 511), 8'(i)}) begin
        miscompares++;
        $display("FAIL midreset_beat %0d: got %h, required %h", i, beats[i], {(i == 511), 8'(i)});
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_tlast_message();
    test_flush();
    test_timeout_stream();
    test_backpressure();
    test_new_byte_wins();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_bulk_packetizer.md
AXIS_BULK_PACKETIZER -- requirements
Module: axis_bulk_packetizer

Interface
REQ-001 SHALL have parameter MAX_PACKET, default 512, max bytes per packet (use 64 for Full-Speed).
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle aclk cycles before a pending short packet is closed; 0 disables the timeout.
REQ-003 SHALL use one clock and an asynchronous active-low reset: aclk (input, 1) is the sole clock; aresetn (input, 1) is the reset.
REQ-004 SHALL have port s_axis_tvalid  input  1  upstream byte valid.
REQ-005 SHALL have port s_axis_tready  output  1  upstream byte accepted.
REQ-006 SHALL have port s_axis_tlast  input  1  upstream end-of-message.
REQ-007 SHALL have port s_axis_tdata  input  8  upstream byte.
REQ-008 SHALL have port m_axis_tvalid  output  1  byte valid toward the bulk IN endpoint.
REQ-009 SHALL have port m_axis_tready  input  1  endpoint ready.
REQ-010 SHALL have port m_axis_tlast  output  1  last byte of a USB packet.
REQ-011 SHALL have port m_axis_tdata  output  8  byte toward the endpoint.
REQ-012 SHALL have port flush  input  1  force-close of any pending packet.
REQ-013 SHALL have port timeout_o  output  1  one-cycle pulse when a packet is closed by timeout.

Function
REQ-014 SHALL hold two registers: HOLD (one byte, tlast undecided) and OUT (drives m_axis_*, m_axis_tvalid = OUT valid).
REQ-015 SHALL treat HOLD as decided when: held s_tlast = 1; byte count = MAX_PACKET-1; flush = 1; or timer = TIMEOUT.
REQ-016 SHALL promote HOLD to OUT when OUT is empty or draining (m_axis_tvalid & m_axis_tready), and either HOLD is decided or a new byte is accepted that cycle.
REQ-017 SHALL set OUT tlast = 1 on promotion iff HOLD is decided.
REQ-018 SHALL, when a new byte is accepted and HOLD is undecided, close the packet only on byte count = MAX_PACKET-1; the new byte wins over a same-cycle timeout.
REQ-019 SHALL assert s_axis_tready = !HOLD valid | promotion this cycle; the next byte is loaded into HOLD in the same cycle.
REQ-020 SHALL keep a byte count of $clog2(MAX_PACKET) bits, incremented on each promotion and cleared on promotion with tlast.
REQ-021 SHALL never emit more than MAX_PACKET bytes between tlasts.
REQ-022 SHALL count the timer only while HOLD is valid, undecided and no byte is accepted; the timer clears on every accepted byte and saturates at TIMEOUT.
REQ-023 SHALL pulse timeout_o for one cycle on a promotion caused solely by the timer.
REQ-024 SHALL give latency of 1 cycle from acceptance to m_axis_tvalid for a decided byte; otherwise m_axis_tvalid follows 1 cycle after the successor is accepted or the packet closes.
REQ-025 SHALL keep OUT stable while m_axis_tvalid & !m_axis_tready, holding HOLD and applying backpressure upstream.
REQ-026 SHALL have no effect when flush is asserted with HOLD empty; no zero-length packets are generated.

Reset
REQ-027 SHALL, on aresetn low, asynchronously clear HOLD, OUT, count, timer: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, timeout_o=0.
REQ-028 SHALL discard a partial packet on reset mid-operation; s_axis_tready returns to 1 on the first aclk edge after release.

Structure
REQ-029 SHALL take MAX_PACKET values (512 High-Speed, 64 Full-Speed) and the default TIMEOUT from the shared USB package.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL cover: 1200-byte stream, no s_tlast, m_tready=1 -> packets of 512, 512, then 176 bytes; tlast after the 176th byte once TIMEOUT=1024 idle cycles elapse, with timeout_o pulsing once.
REQ-032 SHALL cover: 10-byte message with s_tlast on byte 10 -> single 10-byte packet, tlast on byte 10 one cycle after its acceptance, timeout_o=0.
REQ-033 SHALL cover: 3 bytes, then flush at idle cycle 5 -> 3-byte packet with tlast, timeout_o=0; a later flush with HOLD empty -> no output.
REQ-034 SHALL cover: m_tready held 0 for 100 cycles during a stream -> m_axis_* stable, s_tready=0 after two bytes are buffered, no data lost or duplicated.
REQ-035 SHALL cover: aresetn pulsed low mid-packet (byte 300) -> outputs reset immediately; the next stream starts with count 0, first tlast after 512 bytes.
REQ-036 SHALL cover: a new byte accepted in the same cycle the timer reaches TIMEOUT -> no tlast on the held byte, timeout_o=0.
